// File: rtl/calc_pkg.sv
// Shared definitions for calc_top and its display scanner: digit geometry,
// status codes and 7-segment patterns (bit0=a .. bit6=g, 1 = lit).
package calc_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    typedef logic [SEG_W-1:0] seg_t;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_ERR  = 2'b10;

    localparam seg_t SEG_OFF   = 7'h00;
    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_MINUS = 7'h40;
    localparam seg_t SEG_E     = 7'h79;

endpackage

// File: rtl/calc_scan_timer.sv
// Digit-slot timing for the display scanner: per-slot tick, digit index and
// the frame_start strobe (also raised once right after reset release).
module calc_scan_timer
    import calc_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 1000,
    localparam int unsigned TickW = $clog2(DIGIT_CYCLES)
) (
    input  logic             clock,
    input  logic             reset,
    output logic [TickW-1:0] tick_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             frame_start_o
);

    logic [TickW-1:0] tick_q, tick_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             load_pending_q;
    logic             tick_wrap;

    always_comb begin
        tick_wrap = (tick_q == TickW'(DIGIT_CYCLES - 1));
        tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
        // idx is exactly IDX_W bits wide, so 7 -> 0 wraps for free
        idx_d     = tick_wrap ? idx_q + 1'b1 : idx_q;
        frame_start_o = load_pending_q
                      | (tick_wrap & (idx_q == IDX_W'(NUM_DIGITS - 1)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q         <= '0;
            idx_q          <= '0;
            load_pending_q <= 1'b1;
        end else begin
            tick_q         <= tick_d;
            idx_q          <= idx_d;
            load_pending_q <= 1'b0;
        end
    end

    assign tick_o = tick_q;
    assign idx_o  = idx_q;

endmodule

// File: rtl/calc_display_scan.sv
// Time-multiplexed 8-digit common-anode driver: per-frame snapshot of the
// digit patterns, guard blanking between slots and error blinking.
module calc_display_scan
    import calc_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 1000,
    parameter int unsigned GUARD_CYCLES = 1,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  seg_t [NUM_DIGITS-1:0] displays,
    input  logic [1:0]            status,
    output logic [NUM_DIGITS-1:0] an,
    output seg_t                  seg,
    output logic                  frame_sync
);

    localparam int unsigned TickW  = $clog2(DIGIT_CYCLES);
    localparam int unsigned BlinkW = $clog2(BLINK_FRAMES) + 1;

    logic [TickW-1:0]  tick;
    logic [IDX_W-1:0]  idx;
    logic              frame_start;

    seg_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                  err_q, err_d;
    logic [BlinkW-1:0]     blink_cnt_q, blink_cnt_d;
    logic                  blink_on_q, blink_on_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg_t                  seg_q, seg_d;
    logic                  frame_sync_q, frame_sync_d;
    seg_t                  cur;
    logic                  blank;

    calc_scan_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES)
    ) u_timer (
        .clock         (clock),
        .reset         (reset),
        .tick_o        (tick),
        .idx_o         (idx),
        .frame_start_o (frame_start)
    );

    always_comb begin
        shadow_d    = shadow_q;
        err_d       = err_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_start) begin
            shadow_d = displays;
            err_d    = (status == ST_ERR);
            // The first error frame restarts the blink phase lit
            if (!err_d || !err_q) begin
                blink_cnt_d = '0;
                blink_on_d  = 1'b1;
            end else if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        cur   = shadow_q[idx];
        blank = (tick < TickW'(GUARD_CYCLES)) | (err_q & ~blink_on_q) | (cur == SEG_OFF);
        an_d  = blank ? '1 : ~(NUM_DIGITS'(1) << idx);
        seg_d = blank ? '1 : ~cur;
        frame_sync_d = (idx == '0) && (tick == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q     <= '0;
            err_q        <= 1'b0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
            an_q         <= '1;
            seg_q        <= '1;
            frame_sync_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            err_q        <= err_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_sync_q <= frame_sync_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_sync = frame_sync_q;

endmodule
